// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage with loadable instruction memory,
//               program counter, stall, branch redirect and halt detection.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int          DEPTH     = 64,
    parameter int          AW        = 6,
    parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    output logic [31:0]   Inst,
    output logic          inst_valid,
    output logic [31:0]   pc,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;
    logic        r_halted;

    logic [31:0] w_next;
    logic        w_advance;
    logic [31:0] w_word;
    logic        w_is_halt;

    // Program load is only accepted while the fetch engine is not running.
    always_ff @(posedge clk) begin
        if (load_en && (r_state != S_RUN)) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Next fetch address; w_advance marks an edge that moves pc to w_next.
    always_comb begin
        w_next    = r_pc + 32'd4;
        w_advance = 1'b0;
        case (r_state)
            S_RUN: begin
                if (branch_taken) begin
                    w_next    = branch_target & ~32'h3;
                    w_advance = 1'b1;
                end else if (!stall) begin
                    w_advance = 1'b1;
                end
            end
            default: begin
                if (start && !load_en) begin
                    w_next    = 32'd0;
                    w_advance = 1'b1;
                end
            end
        endcase
    end

    // Only the word-index bits address memory; upper pc bits wrap freely.
    assign w_word    = r_mem[w_next[AW+1:2]];
    assign w_is_halt = (w_word == HALT_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= 32'd0;
            r_inst   <= 32'd0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_advance) begin
            r_pc <= w_next;
            if (w_is_halt) begin
                r_state  <= S_HALT;
                r_inst   <= 32'd0;
                r_valid  <= 1'b0;
                r_halted <= 1'b1;
            end else begin
                r_state  <= S_RUN;
                r_inst   <= w_word;
                r_valid  <= 1'b1;
                r_halted <= 1'b0;
            end
        end
    end

    assign Inst       = r_inst;
    assign inst_valid = r_valid;
    assign pc         = r_pc;
    assign halted     = r_halted;

endmodule
`default_nettype wire
